// File: rtl/seq_detector_mealy_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detector_mealy_param: runtime-loadable Mealy serial pattern detector
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_detector_mealy_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in,
  input  logic                     in_valid,
  input  logic                     overlap,
  input  logic                     load,
  input  logic [PAT_W-1:0]         pattern,
  output logic                     detected,
  output logic [$clog2(PAT_W):0]   prs_st,
  output logic [CNT_W-1:0]         det_count
);

  localparam int               FILL_W   = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [PAT_W-2:0]  hist_shift;
  logic              match;

  // A 2-bit pattern keeps a single history bit, so there is nothing to shift through.
  if (PAT_W == 2) begin : g_hist_single
    assign hist_shift = in;
  end else begin : g_hist_shift
    assign hist_shift = {hist_q[PAT_W-3:0], in};
  end

  always_comb begin
    match  = in_valid & ~load & (fill_q == FILL_MAX) & ({hist_q, in} == pat_q);
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      // Non-overlapping mode restarts the fill; stale history is masked by fill.
      if (match && !overlap) begin
        fill_d = '0;
      end
      if (match && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign detected  = match;
  assign prs_st    = fill_q;
  assign det_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_mealy_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_detector_mealy_param: directed bench for seq_detector_mealy_param
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seq_detector_mealy_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in;
  logic       in_valid;
  logic       overlap;
  logic       load;
  logic [3:0] pattern;

  logic       det_a;
  logic [2:0] prs_a;
  logic [7:0] cnt_a;
  logic       det_b;
  logic [2:0] prs_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] STREAM = 16'b1101_0110_1011_0111;

  always #5 clk = ~clk;

  seq_detector_mealy_param #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(8)) u_dut_a (
    .clk(clk), .rstn(rstn), .in(in), .in_valid(in_valid), .overlap(overlap),
    .load(load), .pattern(pattern), .detected(det_a), .prs_st(prs_a), .det_count(cnt_a)
  );

  // Narrow counter instance shares all stimulus; only its saturation is checked.
  seq_detector_mealy_param #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .in(in), .in_valid(in_valid), .overlap(overlap),
    .load(load), .pattern(pattern), .detected(det_b), .prs_st(prs_b), .det_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic exp_det, input string tag);
    @(negedge clk);
    in       = b;
    in_valid = 1'b1;
    load     = 1'b0;
    #1;
    chk(tag, {31'd0, det_a}, {31'd0, exp_det});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    load     = 1'b0;
    #1;
  endtask

  task automatic do_load(input logic [3:0] p);
    @(negedge clk);
    load     = 1'b1;
    pattern  = p;
    in_valid = 1'b1;
    in       = 1'b1;
    #1;
    chk("load_det", {31'd0, det_a}, 32'd0);
    @(negedge clk);
    load     = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("load_prs", {29'd0, prs_a}, 32'd0);
    chk("load_cnt", {24'd0, cnt_a}, 32'd0);
  endtask

  // Sends stream bits first..last; optional stall gaps check the frozen fill
  // against exp_fill (only meaningful for a fresh overlapping run).
  task automatic run_stream(input logic [15:0] s, input int first, input int last,
                            input logic [15:0] mask, input bit gaps, input string tag);
    for (int i = first; i <= last; i++) begin
      send_bit(s[15-i], mask[i], $sformatf("%s_bit%0d", tag, i));
      if (gaps) begin
        for (int g = 0; g < 1 + (i % 3); g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in       = 1'($urandom_range(0, 1));
          #1;
          chk($sformatf("%s_gapdet%0d", tag, i), {31'd0, det_a}, 32'd0);
          if (overlap) begin
            chk($sformatf("%s_gapfill%0d", tag, i), {29'd0, prs_a},
                (i + 1 < 3) ? i + 1 : 3);
          end
        end
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    in       = 1'b1;
    in_valid = 1'b1;
    overlap  = 1'b1;
    load     = 1'b0;
    pattern  = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_det", {31'd0, det_a}, 32'd0);
    chk("rst_prs", {29'd0, prs_a}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rstn     = 1'b1;
    in_valid = 1'b0;

    // Overlapping run: matches end on bits 6, 11, 14.
    overlap = 1'b1;
    run_stream(STREAM, 0, 15, 16'b0100_1000_0100_0000, 1'b0, "ovl");
    idle();
    chk("ovl_cnt", {24'd0, cnt_a}, 32'd3);
    chk("ovl_prs", {29'd0, prs_a}, 32'd3);

    // Non-overlapping: bit 14 lost because fill restarted after bit 11.
    do_load(4'b1011);
    overlap = 1'b0;
    run_stream(STREAM, 0, 15, 16'b0000_1000_0100_0000, 1'b0, "novl");
    idle();
    chk("novl_cnt", {24'd0, cnt_a}, 32'd2);
    chk("novl_prs", {29'd0, prs_a}, 32'd3);

    // All-ones pattern, six ones.
    do_load(4'b1111);
    overlap = 1'b1;
    run_stream(16'hFFFF, 0, 5, 16'b0000_0000_0011_1000, 1'b0, "ones_ovl");
    idle();
    chk("ones_ovl_cnt", {24'd0, cnt_a}, 32'd3);
    do_load(4'b1111);
    overlap = 1'b0;
    run_stream(16'hFFFF, 0, 5, 16'b0000_0000_0000_1000, 1'b0, "ones_novl");
    idle();
    chk("ones_novl_cnt", {24'd0, cnt_a}, 32'd1);
    chk("ones_novl_prs", {29'd0, prs_a}, 32'd2);

    // Stall gaps between every bit must not change detection.
    do_load(4'b1011);
    overlap = 1'b1;
    run_stream(STREAM, 0, 15, 16'b0100_1000_0100_0000, 1'b1, "gap_ovl");
    idle();
    chk("gap_ovl_cnt", {24'd0, cnt_a}, 32'd3);
    do_load(4'b1011);
    overlap = 1'b0;
    run_stream(STREAM, 0, 15, 16'b0000_1000_0100_0000, 1'b1, "gap_novl");
    idle();
    chk("gap_novl_cnt", {24'd0, cnt_a}, 32'd2);

    // Asynchronous reset mid-stream after bit 9, then bits 10..15.
    do_load(4'b1011);
    overlap = 1'b1;
    run_stream(STREAM, 0, 9, 16'b0000_0000_0100_0000, 1'b0, "pre_rst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_prs", {29'd0, prs_a}, 32'd0);
    chk("midrst_cnt", {24'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_stream(STREAM, 10, 15, 16'b0100_0000_0000_0000, 1'b0, "post_rst");
    idle();
    chk("post_rst_cnt", {24'd0, cnt_a}, 32'd1);
    chk("post_rst_prs", {29'd0, prs_a}, 32'd3);

    // Same point, but a load clears state and discards the bit on that cycle.
    do_load(4'b1011);
    run_stream(STREAM, 0, 9, 16'b0000_0000_0100_0000, 1'b0, "pre_ld");
    do_load(4'b1011);
    run_stream(STREAM, 10, 15, 16'b0100_0000_0000_0000, 1'b0, "post_ld");
    idle();
    chk("post_ld_cnt", {24'd0, cnt_a}, 32'd1);

    // Reset restores RST_PAT after a different pattern was loaded.
    do_load(4'b0110);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_stream(16'b1011_0000_0000_0000, 0, 3, 16'b0000_0000_0000_1000, 1'b0, "revert");
    idle();
    chk("revert_cnt", {24'd0, cnt_a}, 32'd1);

    // Saturation: ten ones on 1111 overlap gives seven matches.
    do_load(4'b1111);
    chk("sat_b_clr", {30'd0, cnt_b}, 32'd0);
    overlap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, (i >= 3), $sformatf("sat_a_bit%0d", i));
      chk($sformatf("sat_b_det%0d", i), {31'd0, det_b}, (i >= 3) ? 32'd1 : 32'd0);
    end
    idle();
    chk("sat_b_cnt", {30'd0, cnt_b}, 32'd3);
    chk("sat_a_cnt", {24'd0, cnt_a}, 32'd7);
    send_bit(1'b1, 1'b1, "sat_extra");
    idle();
    chk("sat_b_hold", {30'd0, cnt_b}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
